// File: rtl/line_buf_pkg.sv
// Shared types and constants for the vertical-window line buffer.
package line_buf_pkg;

    localparam int BORDER_RAW  = 0;
    localparam int BORDER_ZERO = 1;
    localparam int BORDER_REPL = 2;

    localparam int PIX_W = 8;
    typedef logic [PIX_W-1:0] pixel_t;

    function automatic int col_w(input int max_width);
        return (max_width > 1) ? $clog2(max_width) : 1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// One line of pixel storage: asynchronous read, synchronous write, no reset.
module line_ram
    import line_buf_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = col_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_window_buffer.sv
// Emits a BUF_DEPTH-tall pixel column per valid input pixel, with line-length
// tracking, top-border handling and sticky over-length detection.
module line_window_buffer
    import line_buf_pkg::*;
#(
    parameter int COLORDEPTH  = 8,
    parameter int BUF_DEPTH   = 3,
    parameter int MAX_WIDTH   = 1024,
    parameter int BORDER_MODE = BORDER_REPL
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [COLORDEPTH-1:0]                 data_i,
    input  logic                                  dv_i,
    input  logic                                  hs_i,
    input  logic                                  vs_i,
    input  logic                                  line_end_i,
    output logic [BUF_DEPTH-1:0][COLORDEPTH-1:0]  buff_o,
    output logic                                  dv_o,
    output logic                                  hs_o,
    output logic                                  vs_o,
    output logic [BUF_DEPTH-1:0]                  tap_valid_o,
    output logic [$clog2(MAX_WIDTH+1)-1:0]        line_len_o,
    output logic                                  ovf_o
);

    localparam int CW    = col_w(MAX_WIDTH);
    localparam int LW    = $clog2(BUF_DEPTH);
    localparam int LEN_W = $clog2(MAX_WIDTH+1);
    localparam int NR    = BUF_DEPTH - 1;

    logic [CW-1:0]    col_q, col_d, col_eff;
    logic [LW-1:0]    lines_q, lines_d, lines_eff;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d, vs_q, hs_q, dv_q, frame_start;
    logic [BUF_DEPTH-1:0][COLORDEPTH-1:0] buff_q, buff_d;
    logic [BUF_DEPTH-1:0]                 tap_q, tap_d;
    logic [NR-1:0][COLORDEPTH-1:0]        rd, wd;
    logic [COLORDEPTH-1:0]                repl;

    // A frame start overrides the counters in the same cycle, so a pixel
    // arriving with the vs edge lands in column 0 of line 0.
    assign frame_start = vs_i & ~vs_q;
    assign col_eff     = frame_start ? '0 : col_q;
    assign lines_eff   = frame_start ? '0 : lines_q;

    for (genvar k = 0; k < NR; k++) begin : g_ram
        line_ram #(.W(COLORDEPTH), .DEPTH(MAX_WIDTH)) u_ram (
            .clk    (clk),
            .we_i   (dv_i),
            .addr_i (col_eff),
            .wdata_i(wd[k]),
            .rdata_o(rd[k])
        );
    end

    always_comb begin : cascade
        wd    = '0;
        wd[0] = data_i;
        for (int k = 1; k < NR; k++) wd[k] = rd[k-1];
    end

    always_comb begin : window
        repl = data_i;
        for (int k = 1; k < BUF_DEPTH; k++)
            if (int'(lines_eff) == k) repl = rd[k-1];
        tap_d     = '0;
        buff_d    = '0;
        tap_d[0]  = 1'b1;
        buff_d[0] = data_i;
        for (int k = 1; k < BUF_DEPTH; k++) begin
            tap_d[k] = (int'(lines_eff) >= k);
            if (tap_d[k])                         buff_d[k] = rd[k-1];
            else if (BORDER_MODE == BORDER_ZERO)  buff_d[k] = '0;
            else if (BORDER_MODE == BORDER_REPL)  buff_d[k] = repl;
            else                                  buff_d[k] = rd[k-1];
        end
    end

    always_comb begin : counters
        col_d   = col_eff;
        lines_d = lines_eff;
        len_d   = len_q;
        ovf_d   = ovf_q & ~frame_start;
        if (dv_i) begin
            if (line_end_i) begin
                col_d = '0;
                len_d = LEN_W'(col_eff) + LEN_W'(1);
                if (lines_eff != LW'(NR)) lines_d = lines_eff + LW'(1);
            end else if (col_eff == CW'(MAX_WIDTH-1)) begin
                ovf_d = 1'b1;
            end else begin
                col_d = col_eff + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q   <= '0;
            lines_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            dv_q    <= 1'b0;
            buff_q  <= '0;
            tap_q   <= '0;
        end else begin
            col_q   <= col_d;
            lines_q <= lines_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            vs_q    <= vs_i;
            hs_q    <= hs_i;
            dv_q    <= dv_i;
            if (dv_i) begin
                buff_q <= buff_d;
                tap_q  <= tap_d;
            end
        end
    end

    assign buff_o      = buff_q;
    assign tap_valid_o = tap_q;
    assign dv_o        = dv_q;
    assign hs_o        = hs_q;
    assign vs_o        = vs_q;
    assign line_len_o  = len_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench: two buffers (zero and replicate border) share one stream,
// checked against a per-column pixel-history model.
module tb_line_window_buffer;

    localparam int CD = 8;
    localparam int BD = 3;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [CD-1:0] data_i = '0;
    logic dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0, le_i = 1'b0;

    logic [BD-1:0][CD-1:0] z_buff, r_buff;
    logic z_dv, z_hs, z_vs, z_ovf, r_dv, r_hs, r_vs, r_ovf;
    logic [BD-1:0] z_tap, r_tap;
    logic [3:0] z_len, r_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_window_buffer #(.COLORDEPTH(CD), .BUF_DEPTH(BD), .MAX_WIDTH(MW), .BORDER_MODE(1)) u_zero (
        .clk(clk), .rst(rst), .data_i(data_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .line_end_i(le_i), .buff_o(z_buff), .dv_o(z_dv), .hs_o(z_hs), .vs_o(z_vs),
        .tap_valid_o(z_tap), .line_len_o(z_len), .ovf_o(z_ovf));

    line_window_buffer #(.COLORDEPTH(CD), .BUF_DEPTH(BD), .MAX_WIDTH(MW), .BORDER_MODE(2)) u_repl (
        .clk(clk), .rst(rst), .data_i(data_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .line_end_i(le_i), .buff_o(r_buff), .dv_o(r_dv), .hs_o(r_hs), .vs_o(r_vs),
        .tap_valid_o(r_tap), .line_len_o(r_len), .ovf_o(r_ovf));

    typedef struct {
        logic [BD-1:0][CD-1:0] bz, br;
        logic [BD-1:0] tap;
        logic dv, hs, vs;
        logic [3:0] len;
        logic ovf;
    } exp_t;

    exp_t sb[$];

    // Model state: frame position plus every pixel ever written per column.
    int m_col, m_lines, m_len;
    bit m_ovf, m_vsp;
    logic [BD-1:0][CD-1:0] m_bz, m_br;
    logic [BD-1:0] m_tap;
    logic [CD-1:0] chist [MW][$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_lines = 0; m_len = 0; m_ovf = 0; m_vsp = 0;
        m_bz = '0; m_br = '0; m_tap = '0;
    endtask

    task automatic model_step(input logic [CD-1:0] d, input logic dv, hs, vs, le, output exp_t e);
        logic [CD-1:0] raw [BD];
        logic [CD-1:0] oldest;
        int n;
        if (vs && !m_vsp) begin
            m_col = 0; m_lines = 0; m_ovf = 0;
        end
        m_vsp = vs;
        if (dv) begin
            n = chist[m_col].size();
            for (int k = 1; k < BD; k++) raw[k] = (n >= k) ? chist[m_col][n-k] : '0;
            oldest = (m_lines == 0) ? d : raw[m_lines];
            m_bz[0] = d; m_br[0] = d; m_tap = '0; m_tap[0] = 1'b1;
            for (int k = 1; k < BD; k++) begin
                m_tap[k] = (k <= m_lines);
                m_bz[k] = (k <= m_lines) ? raw[k] : '0;
                m_br[k] = (k <= m_lines) ? raw[k] : oldest;
            end
            chist[m_col].push_back(d);
            if (chist[m_col].size() > BD) void'(chist[m_col].pop_front());
            if (le) begin
                m_len = m_col + 1; m_col = 0;
                m_lines = (m_lines + 1 > BD - 1) ? BD - 1 : m_lines + 1;
            end else if (m_col == MW - 1) m_ovf = 1;
            else m_col++;
        end
        e.bz = m_bz; e.br = m_br; e.tap = m_tap;
        e.dv = dv; e.hs = hs; e.vs = vs; e.len = 4'(m_len); e.ovf = m_ovf;
    endtask

    task automatic step(input logic [CD-1:0] d, input logic dv, hs, vs, le);
        exp_t e;
        data_i = d; dv_i = dv; hs_i = hs; vs_i = vs; le_i = le;
        model_step(d, dv, hs, vs, le, e);
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic px(input logic [CD-1:0] d, input logic le);
        step(d, 1'b1, 1'b0, 1'b0, le);
    endtask

    task automatic vsync();
        step('0, 1'b0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic blank();
        step('0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("z_buff", 64'(z_buff), 64'(e.bz));
            chk("r_buff", 64'(r_buff), 64'(e.br));
            chk("z_tap", 64'(z_tap), 64'(e.tap));
            chk("r_tap", 64'(r_tap), 64'(e.tap));
            chk("z_sync", {z_dv, z_hs, z_vs}, {e.dv, e.hs, e.vs});
            chk("r_sync", {r_dv, r_hs, r_vs}, {e.dv, e.hs, e.vs});
            chk("z_len_ovf", {z_len, z_ovf}, {e.len, e.ovf});
            chk("r_len_ovf", {r_len, r_ovf}, {e.len, e.ovf});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rows, w;
        model_reset();
        #1;
        chk("rst_z", {z_buff, z_tap, z_dv, z_hs, z_vs, z_len, z_ovf}, 64'h0);
        chk("rst_r", {r_buff, r_tap, r_dv, r_hs, r_vs, r_len, r_ovf}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Frame A: three full lines, data = 16*line + x
        vsync();
        for (int r = 0; r < 3; r++) begin
            for (int x = 0; x < 8; x++) begin
                px(8'(16*r + x), x == 7);
                if (r == 0 && x == 2) begin
                    chk("a_l0_zbuff", 64'(z_buff), 64'h000002);
                    chk("a_l0_rbuff", 64'(r_buff), 64'h020202);
                    chk("a_l0_tap", 64'(z_tap), 64'h1);
                end
                if (r == 2 && x == 5) begin
                    chk("a_l2_zbuff", 64'(z_buff), 64'h051525);
                    chk("a_l2_tap", 64'(z_tap), 64'h7);
                end
            end
            blank();
        end

        // Frame B: replicate border on the second line
        vsync();
        for (int r = 0; r < 2; r++) begin
            for (int x = 0; x < 8; x++) begin
                px(8'(16*r + x), x == 7);
                if (r == 1 && x == 3) begin
                    chk("b_rbuff", 64'(r_buff), 64'h030313);
                    chk("b_zbuff", 64'(z_buff), 64'h000313);
                    chk("b_tap", 64'(r_tap), 64'h3);
                end
            end
            blank();
        end

        // Frame C: lines of 6, 4 then 6 pixels
        vsync();
        for (int x = 0; x < 6; x++) px(8'(x), x == 5);
        chk("c_len6", 64'(z_len), 64'd6);
        blank();
        for (int x = 0; x < 4; x++) px(8'(16 + x), x == 3);
        chk("c_len4", 64'(z_len), 64'd4);
        blank();
        for (int x = 0; x < 6; x++) begin
            px(8'(32 + x), x == 5);
            if (x == 2) chk("c_col2", 64'(z_buff), 64'h021222);
        end
        blank();

        // Frame D: 10-pixel line against MAX_WIDTH = 8
        vsync();
        for (int x = 0; x < 10; x++) begin
            px(8'(x), x == 9);
            if (x == 6) chk("d_ovf_lo", 64'(z_ovf), 64'd0);
            if (x == 8) chk("d_ovf_hi", 64'(z_ovf), 64'd1);
        end
        chk("d_len_sat", 64'(z_len), 64'd8);
        blank();
        for (int x = 0; x < 3; x++) px(8'(16 + x), x == 2);
        chk("d_ovf_sticky", 64'(r_ovf), 64'd1);
        step('0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("d_ovf_clr", 64'(z_ovf), 64'd0);
        step('0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Frame E: vs edge together with dv & line_end
        for (int x = 0; x < 4; x++) px(8'(x), x == 3);
        blank();
        px(8'h40, 1'b0);
        px(8'h41, 1'b0);
        step(8'h77, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("e_tap", 64'(z_tap), 64'h1);
        chk("e_len", 64'(z_len), 64'd1);
        chk("e_zbuff", 64'(z_buff), 64'h000077);
        step('0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(8'h50, 1'b1);
        blank();

        // Random frames with gaps, stray line_end and over-length lines
        for (int f = 0; f < 6; f++) begin
            step('0, 1'b0, 1'b0, 1'b1, 1'b0);
            if ($urandom_range(1) == 1) step('0, 1'b0, 1'b0, 1'b1, 1'b0);
            step('0, 1'b0, 1'b0, 1'b0, 1'b0);
            rows = $urandom_range(1, 4);
            for (int r = 0; r < rows; r++) begin
                w = $urandom_range(1, 10);
                for (int x = 0; x < w; x++) begin
                    while ($urandom_range(3) == 0)
                        step(8'($urandom), 1'b0, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
                    px(8'($urandom), x == w - 1);
                end
                blank();
            end
        end

        // Asynchronous reset mid-line at column 5
        vsync();
        for (int x = 0; x < 8; x++) px(8'(x), x == 7);
        blank();
        for (int x = 0; x < 5; x++) px(8'(16 + x), 1'b0);
        @(negedge clk); #1;
        data_i = '0; dv_i = 0; hs_i = 0; vs_i = 0; le_i = 0;
        rst = 1'b0;
        #1;
        chk("mid_rst_z", {z_buff, z_tap, z_dv, z_hs, z_vs, z_len, z_ovf}, 64'h0);
        chk("mid_rst_r", {r_buff, r_tap, r_dv, r_hs, r_vs, r_len, r_ovf}, 64'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        px(8'hA0, 1'b0);
        chk("post_rst_tap", 64'(z_tap), 64'h1);
        chk("post_rst_buff", 64'(z_buff), 64'h0000A0);
        for (int x = 1; x < 4; x++) px(8'(8'hA0 + x), x == 3);
        blank();
        chk("post_rst_sync_hs", {z_dv, z_hs, z_vs}, 3'b010);
        px(8'hB0, 1'b0);
        chk("post_rst_col0_z", 64'(z_buff), 64'h00A0B0);
        chk("post_rst_col0_r", 64'(r_buff), 64'hA0A0B0);
        step(8'hB1, 1'b1, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_sync_vs", {r_dv, r_hs, r_vs}, 3'b001);
        step('0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
